// File: rtl/trace_buffer_pkg.sv
// Shared types and helpers for the trace buffer: FSM state encoding and pointer sizing.
package trace_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACE   = 2'd1,
        FETCH   = 2'd2,
        PRESENT = 2'd3
    } tb_state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trace_buffer_ram.sv
// Simple dual-port vector store: one write port, one registered read port.
// Only the read register is reset so the drained output starts at zero.
module trace_buffer_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 256,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_buffer.sv
// Circular trace capture behind the packer; drains oldest-first over valid/ready
// once tracing drops, keeping the newest DEPTH vectors on overflow.
//
// state   | meaning
// IDLE    | nothing captured or drain finished; waiting for tracing
// TRACE   | capturing every valid_in vector into the ring
// FETCH   | read of mem[rd_ptr] issued
// PRESENT | vector_out valid, waiting for ready_in
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               tracing,
    input  logic                               valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]       vector_in,
    input  logic                               ready_in,
    output logic [N-1:0][DATA_WIDTH-1:0]       vector_out,
    output logic                               valid_out,
    output logic [$clog2(DEPTH+1)-1:0]         count_out,
    output logic                               wrapped_out
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int VW = N * DATA_WIDTH;

    tb_state_t         state, state_nxt;
    logic [AW-1:0]     wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]     rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic              wrapped, wrapped_nxt;
    logic              wr_en, rd_en;
    logic [AW-1:0]     wr_addr;
    logic [VW-1:0]     wr_data, rd_data;

    assign wr_data     = vector_in;
    assign vector_out  = rd_data;
    assign count_out   = count;
    assign wrapped_out = wrapped;

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        count_nxt   = count;
        wrapped_nxt = wrapped;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wr_addr     = wr_ptr;

        // Starting a trace from any non-TRACE state (including a drain abort)
        // wipes the ring and may take a write at address 0 in the same cycle.
        if (tracing && state != TRACE) begin
            state_nxt   = TRACE;
            wr_ptr_nxt  = '0;
            rd_ptr_nxt  = '0;
            count_nxt   = '0;
            wrapped_nxt = 1'b0;
            wr_addr     = '0;
            if (valid_in) begin
                wr_en      = 1'b1;
                wr_ptr_nxt = AW'(1);
                count_nxt  = CW'(1);
            end
        end else begin
            case (state)
                TRACE: begin
                    if (tracing) begin
                        if (valid_in) begin
                            wr_en      = 1'b1;
                            wr_ptr_nxt = wr_ptr + AW'(1);
                            if (count == CW'(DEPTH)) begin
                                rd_ptr_nxt  = rd_ptr + AW'(1);
                                wrapped_nxt = 1'b1;
                            end else begin
                                count_nxt = count + CW'(1);
                            end
                        end
                    end else begin
                        state_nxt = (count != '0) ? FETCH : IDLE;
                    end
                end
                FETCH: begin
                    rd_en     = 1'b1;
                    state_nxt = PRESENT;
                end
                PRESENT: begin
                    if (ready_in) begin
                        rd_ptr_nxt = rd_ptr + AW'(1);
                        count_nxt  = count - CW'(1);
                        state_nxt  = (count == CW'(1)) ? IDLE : FETCH;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            wrapped   <= wrapped_nxt;
            valid_out <= (state_nxt == PRESENT);
        end
    end

    trace_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (VW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: queue-based scoreboard of captured vectors,
// compared against the drained output in order.
module tb_trace_buffer;
    import trace_buffer_pkg::*;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int VW    = N * DW;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          tracing;
    logic          valid_in;
    vec_t          vector_in;
    logic          ready_in;
    vec_t          vector_out;
    logic          valid_out;
    logic [CW-1:0] count_out;
    logic          wrapped_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t q[$];
    vec_t exp_v;

    trace_buffer #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .tracing     (tracing),
        .valid_in    (valid_in),
        .vector_in   (vector_in),
        .ready_in    (ready_in),
        .vector_out  (vector_out),
        .valid_out   (valid_out),
        .count_out   (count_out),
        .wrapped_out (wrapped_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk_vec(input int v);
        vec_t r;
        for (int i = 0; i < N; i++) begin
            r[i] = DW'(v) ^ (DW'(i) << 24);
        end
        return r;
    endfunction

    // Capture n consecutive vectors, then drop tracing and valid_in together.
    task automatic trace_write(input int first, input int n);
        tracing  = 1'b1;
        valid_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            vector_in = mk_vec(first + i);
            q.push_back(vector_in);
            if (q.size() > DEPTH) void'(q.pop_front());
            step();
        end
        valid_in = 1'b0;
        tracing  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget   = 0;
        ready_in = 1'b1;
        while (q.size() != 0 && budget < 100) begin
            if (valid_out === 1'b1) begin
                exp_v = q.pop_front();
                check(tag, vector_out, exp_v);
            end
            step();
            budget++;
        end
        check({tag, "_left"}, q.size(), 0);
        step();
        step();
        check({tag, "_count"}, count_out, 0);
        check({tag, "_valid"}, valid_out, 0);
        check({tag, "_state"}, dut.state, IDLE);
    endtask

    initial begin
        reset     = 1'b1;
        tracing   = 1'b0;
        valid_in  = 1'b0;
        vector_in = '0;
        ready_in  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", valid_out, 0);
        check("rst_vector", vector_out, 0);
        check("rst_count", count_out, 0);
        check("rst_wrapped", wrapped_out, 0);

        // Basic capture and drain with exact timing
        q.delete();
        trace_write(10, 3);
        check("basic_count", count_out, 3);
        ready_in = 1'b1;
        step();
        check("basic_fetch_valid", valid_out, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            check("basic_valid", valid_out, 1);
            exp_v = q.pop_front();
            check("basic_data", vector_out, exp_v);
            check("basic_count_pres", count_out, 3 - k);
            step();
            check("basic_gap_valid", valid_out, 0);
            check("basic_count_pop", count_out, 2 - k);
            step();
        end
        check("basic_state", dut.state, IDLE);
        check("basic_wrapped", wrapped_out, 0);

        // Overflow keeps newest DEPTH entries
        q.delete();
        trace_write(0, 20);
        check("ovf_count", count_out, DEPTH);
        check("ovf_wrapped", wrapped_out, 1);
        drain("ovf_drain");
        check("ovf_wrapped_after", wrapped_out, 1);

        // Back-pressure holds the presented vector
        q.delete();
        trace_write(30, 3);
        check("bp_wrapped_cleared", wrapped_out, 0);
        ready_in = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", valid_out, 1);
            check("bp_data", vector_out, q[0]);
            check("bp_count", count_out, 3);
            step();
        end
        ready_in = 1'b1;
        void'(q.pop_front());
        step();
        check("bp_one_pop", count_out, 2);
        check("bp_valid_drop", valid_out, 0);
        drain("bp_drain");

        // Drain abort restarts capture with a write at address 0
        q.delete();
        trace_write(40, 5);
        ready_in = 1'b0;
        step();
        step();
        check("abort_pre_valid", valid_out, 1);
        check("abort_pre_count", count_out, 5);
        tracing   = 1'b1;
        valid_in  = 1'b1;
        vector_in = mk_vec(99);
        q.delete();
        q.push_back(vector_in);
        step();
        tracing  = 1'b0;
        valid_in = 1'b0;
        check("abort_valid", valid_out, 0);
        check("abort_count", count_out, 1);
        check("abort_wrapped", wrapped_out, 0);
        drain("abort_drain");

        // valid_in ignored in IDLE; empty trace returns to IDLE silently
        valid_in  = 1'b1;
        vector_in = mk_vec(7);
        step();
        step();
        check("idle_ignore_count", count_out, 0);
        valid_in = 1'b0;
        tracing  = 1'b1;
        for (int k = 0; k < 4; k++) step();
        tracing = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("empty_valid", valid_out, 0);
        end
        check("empty_state", dut.state, IDLE);
        check("empty_count", count_out, 0);

        // Reset mid-drain discards everything
        q.delete();
        trace_write(50, 18);
        check("rstd_wrapped_pre", wrapped_out, 1);
        ready_in = 1'b0;
        step();
        step();
        check("rstd_valid_pre", valid_out, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstd_valid", valid_out, 0);
        check("rstd_count", count_out, 0);
        check("rstd_wrapped", wrapped_out, 0);
        check("rstd_vector", vector_out, 0);
        q.delete();
        ready_in = 1'b1;
        tracing  = 1'b1;
        step();
        tracing = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rstd_empty_valid", valid_out, 0);
        end
        check("rstd_state", dut.state, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
